// File: rtl/axis_bram_pkg.sv
// Shared definitions for the BRAM stream packer/reader pair.
// Holds the FSM state encoding, the line-width helper and the word-index width
// helper. Both sides of the BRAM link import these, so their widths always agree.
package axis_bram_pkg;

   // Reader control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Width of one BRAM line in bits
   function automatic int line_w(input int word_width, input int words_per_line);
      return word_width * words_per_line;
   endfunction

   // Width of the index that selects a word within a line
   function automatic int word_idx_w(input int words_per_line);
      return (words_per_line > 1) ? $clog2(words_per_line) : 1;
   endfunction

endpackage

// File: rtl/axis_bram_line_serializer.sv
// Two-entry line buffer and word serialiser for the BRAM stream reader.
// cur drains one word per tvalid&tready handshake, most significant word first.
// nxt holds a prefetched line so that a line boundary costs no bubble.
// A line that arrives while cur is (or is about to become) empty goes straight into cur.
module axis_bram_line_serializer
   import axis_bram_pkg::*;
#(
   parameter  int WORD_WIDTH         = 16,
   parameter  int BRAM_WIDTH_IN_WORD = 36,
   localparam int LINE_W             = line_w(WORD_WIDTH, BRAM_WIDTH_IN_WORD)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  load_valid,
   input  logic [LINE_W-1:0]     load_data,
   input  logic                  load_last,
   input  logic                  tready,
   output logic [WORD_WIDTH-1:0] tdata,
   output logic                  tvalid,
   output logic                  tlast,
   output logic                  next_valid,
   output logic                  final_hs
);

   localparam int               IDX_W    = word_idx_w(BRAM_WIDTH_IN_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BRAM_WIDTH_IN_WORD - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [LINE_W-1:0] cur_data;
   logic [LINE_W-1:0] nxt_data;
   logic              cur_valid;
   logic              nxt_valid;
   logic              cur_last;
   logic              nxt_last;
   logic [IDX_W-1:0]  word_idx;

   logic hs;
   logic at_last_word;
   logic line_end;
   logic cur_free;

   assign hs           = cur_valid & tready;
   assign at_last_word = (word_idx == LAST_IDX);
   assign line_end     = hs & at_last_word;
   // cur can accept a new line this cycle: it is empty or its last word is leaving
   assign cur_free     = ~cur_valid | line_end;

   // cur_data shifts left per beat, so the outgoing word is always its top slice
   assign tdata      = cur_data[LINE_W-1 -: WORD_WIDTH];
   assign tvalid     = cur_valid;
   assign tlast      = cur_valid & cur_last & at_last_word;
   assign next_valid = nxt_valid;
   assign final_hs   = line_end & cur_last;

   // Buffer fill, drain and word advance
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the line buffers are reset as well, so tdata reads 0 straight out of reset.
         cur_data  <= '0;
         nxt_data  <= '0;
         cur_valid <= 1'b0;
         nxt_valid <= 1'b0;
         cur_last  <= 1'b0;
         nxt_last  <= 1'b0;
         word_idx  <= '0;
      end else if (clear) begin
         cur_valid <= 1'b0;
         nxt_valid <= 1'b0;
         cur_last  <= 1'b0;
         nxt_last  <= 1'b0;
         word_idx  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; later assignments in this block
         // deliberately override earlier ones for the same register in the same cycle.
         if (line_end) begin
            word_idx <= '0;
         end else if (hs) begin
            word_idx <= word_idx + IDX_ONE;
            cur_data <= cur_data << WORD_WIDTH;
         end

         if (cur_free) begin
            if (nxt_valid) begin
               cur_data  <= nxt_data;
               cur_last  <= nxt_last;
               cur_valid <= 1'b1;
               nxt_valid <= 1'b0;
            end else if (load_valid) begin
               cur_data  <= load_data;
               cur_last  <= load_last;
               cur_valid <= 1'b1;
            end else begin
               cur_valid <= 1'b0;
            end
         end

         // Arriving line parks in nxt unless it was forwarded straight into cur
         if (load_valid && !(cur_free && !nxt_valid)) begin
            nxt_data  <= load_data;
            nxt_last  <= load_last;
            nxt_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_bram_stream_reader.sv
// Reads BRAM lines start..bound (inclusive, address wraps) and streams them out
// as WORD_WIDTH-bit AXI-Stream beats with full tready backpressure.
// The top holds the control FSM, the line address/count and prefetch issue;
// axis_bram_line_serializer holds the two line buffers and the beat handshake.
// Optional feature macro: AXIS_BRAM_READER_STALL_CNT_EN adds a 32-bit stall_cnt
// output counting stalled streaming cycles (tvalid & !tready).
module axis_bram_stream_reader
   import axis_bram_pkg::*;
#(
   parameter  int BRAM_ADDR_LENGTH   = 12,
   parameter  int BRAM_WIDTH_IN_WORD = 36,
   parameter  int WORD_WIDTH         = 16,
   localparam int LINE_W             = line_w(WORD_WIDTH, BRAM_WIDTH_IN_WORD)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start,
   input  logic [BRAM_ADDR_LENGTH-1:0] bram_start_index,
   input  logic [BRAM_ADDR_LENGTH-1:0] bram_bound_index,
   output logic                        bram_en,
   output logic [BRAM_ADDR_LENGTH-1:0] bram_index,
   input  logic [LINE_W-1:0]           bram_rdata,
   output logic [WORD_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        busy,
   output logic                        done
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
   ,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam logic [BRAM_ADDR_LENGTH-1:0] ADDR_ONE = BRAM_ADDR_LENGTH'(1);

   state_t                      state;
   logic [BRAM_ADDR_LENGTH-1:0] lines_rem;   // lines still to be issued after the last one read
   logic                        issue_last;  // the read currently on bram_en is the bound line
   logic                        rd_valid_q;  // bram_rdata carries a requested line this cycle
   logic                        rd_last_q;   // ... and that line is the bound line

   logic start_acc;
   logic next_valid;
   logic final_hs;
   logic prefetch_ok;

   assign start_acc   = (state == IDLE) & start;
   // Only one read in flight: nothing on bram_en, nothing landing, nxt free, lines left
   assign prefetch_ok = ~next_valid & ~bram_en & ~rd_valid_q & (lines_rem != '0);

   // Control FSM with address counter and prefetch issue
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         bram_en    <= 1'b0;
         bram_index <= '0;
         lines_rem  <= '0;
         issue_last <= 1'b0;
      end else begin
         bram_en <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= FETCH;
                  busy       <= 1'b1;
                  bram_en    <= 1'b1;
                  bram_index <= bram_start_index;
                  lines_rem  <= bram_bound_index - bram_start_index;
                  issue_last <= (bram_bound_index == bram_start_index);
               end
            end
            FETCH: begin
               if (rd_valid_q) state <= STREAM;
            end
            STREAM: begin
               if (final_hs) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (prefetch_ok) begin
                  bram_en    <= 1'b1;
                  bram_index <= bram_index + ADDR_ONE;
                  lines_rem  <= lines_rem - ADDR_ONE;
                  issue_last <= (lines_rem == ADDR_ONE);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Track the read one cycle behind bram_en, when its data is on bram_rdata
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         rd_valid_q <= bram_en;
         rd_last_q  <= issue_last;
      end
   end

   axis_bram_line_serializer #(
      .WORD_WIDTH         (WORD_WIDTH),
      .BRAM_WIDTH_IN_WORD (BRAM_WIDTH_IN_WORD)
   ) u_serializer (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (start_acc),
      .load_valid (rd_valid_q),
      .load_data  (bram_rdata),
      .load_last  (rd_last_q),
      .tready     (m_axis_tready),
      .tdata      (m_axis_tdata),
      .tvalid     (m_axis_tvalid),
      .tlast      (m_axis_tlast),
      .next_valid (next_valid),
      .final_hs   (final_hs)
   );

`ifdef AXIS_BRAM_READER_STALL_CNT_EN
   // Saturating count of streaming cycles where the sink holds off a valid beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (start_acc) begin
         stall_cnt <= '0;
      end else if ((state == STREAM) && m_axis_tvalid && !m_axis_tready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_bram_stream_reader.sv
// Directed bench for axis_bram_stream_reader with a 1-cycle-latency BRAM model.
// Line n, word k of the model reads {n[7:0], k[7:0]}.
module tb_axis_bram_stream_reader;

   localparam int AW  = 12;
   localparam int WPL = 36;
   localparam int WW  = 16;
   localparam int LW  = WW * WPL;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_idx = '0;
   logic [AW-1:0] bound_idx = '0;
   logic          bram_en;
   logic [AW-1:0] bram_index;
   logic [LW-1:0] bram_rdata = '0;
   logic [WW-1:0] tdata;
   logic          tvalid;
   logic          tready = 1'b1;
   logic          tlast;
   logic          busy;
   logic          done;
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // monitor log
   int            cyc = 0;
   logic [WW-1:0] beat_q[$];
   bit            last_q[$];
   int            hs_cyc[$];
   logic [AW-1:0] idx_q[$];
   int            en_first = -1;
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            stab_err = 0;
   bit            prev_stall = 1'b0;
   logic [WW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   axis_bram_stream_reader #(
      .BRAM_ADDR_LENGTH   (AW),
      .BRAM_WIDTH_IN_WORD (WPL),
      .WORD_WIDTH         (WW)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .start            (start),
      .bram_start_index (start_idx),
      .bram_bound_index (bound_idx),
      .bram_en          (bram_en),
      .bram_index       (bram_index),
      .bram_rdata       (bram_rdata),
      .m_axis_tdata     (tdata),
      .m_axis_tvalid    (tvalid),
      .m_axis_tready    (tready),
      .m_axis_tlast     (tlast),
      .busy             (busy),
      .done             (done)
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
      ,
      .stall_cnt        (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] n);
      logic [LW-1:0] l;
      l = '0;
      for (int k = 0; k < WPL; k++) l[LW-1-k*WW -: WW] = {n[7:0], 8'(k)};
      return l;
   endfunction

   // BRAM model: data valid the cycle after bram_en
   always @(posedge clk) if (bram_en) bram_rdata <= line_of(bram_index);

   // Monitor: beats, reads, done pulses and stall stability, sampled mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!tvalid || tdata != prev_data || tlast != prev_last)) stab_err++;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         if (tvalid && tready) begin
            beat_q.push_back(tdata);
            last_q.push_back(tlast);
            hs_cyc.push_back(cyc);
         end
         if (bram_en) begin
            idx_q.push_back(bram_index);
            if (en_first < 0) en_first = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic reset_log();
      beat_q.delete();
      last_q.delete();
      hs_cyc.delete();
      idx_q.delete();
      en_first = -1;
      done_cnt = 0;
      done_cyc = 0;
      stab_err = 0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] b);
      @(posedge clk); #1;
      start_idx = s;
      bound_idx = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   // mode 0: tready=1; mode 1: random tready; mode 2: 10-cycle stall at beat 50
   task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] b, input int mode,
                           input bit poke_busy, input bit poke_done, input string tag);
      logic [AW-1:0] diff;
      logic [AW-1:0] n;
      int            lines;
      int            beats;
      int            data_err;
      int            idx_err;
      int            last_cnt;
      int            stall_left;
      bit            hit;
      diff       = b - s;
      lines      = int'(diff) + 1;
      stall_left = 10;
      hit        = 1'b0;
      reset_log();
      pulse_start(s, b);
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         if (done) begin
            hit = 1'b1;
            break;
         end
         if (mode == 1) tready = 1'($urandom_range(0, 1));
         else if (mode == 2 && beat_q.size() >= 50 && stall_left > 0) begin
            tready = 1'b0;
            stall_left--;
         end else tready = 1'b1;
         if (poke_busy && c == 20) begin
            start     = 1'b1;
            start_idx = 12'h009;
            bound_idx = 12'h009;
         end else start = 1'b0;
      end
      check({tag, "_done_seen"}, longint'(hit), 1);
      if (poke_done) begin
         start_idx = 12'h00A;
         bound_idx = 12'h00A;
         start     = 1'b1;
      end
      @(posedge clk); #1;
      start  = 1'b0;
      tready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      beats = lines * WPL;
      check({tag, "_beats"}, beat_q.size(), beats);
      data_err = 0;
      last_cnt = 0;
      for (int i = 0; i < beat_q.size() && i < beats; i++) begin
         n = s + AW'(i / WPL);
         if (beat_q[i] != {n[7:0], 8'(i % WPL)}) data_err++;
      end
      foreach (last_q[i]) if (last_q[i]) last_cnt++;
      check({tag, "_data_err"}, data_err, 0);
      check({tag, "_tlast_cnt"}, last_cnt, 1);
      if (last_q.size() > 0) check({tag, "_tlast_on_final"}, longint'(last_q[last_q.size()-1]), 1);
      check({tag, "_bram_en_cnt"}, idx_q.size(), lines);
      idx_err = 0;
      for (int i = 0; i < idx_q.size() && i < lines; i++) if (idx_q[i] != s + AW'(i)) idx_err++;
      check({tag, "_index_err"}, idx_err, 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
      if (hs_cyc.size() > 0) check({tag, "_done_lat"}, done_cyc - hs_cyc[hs_cyc.size()-1], 1);
      check({tag, "_busy_after"}, longint'(busy), 0);
      if (mode == 0 && hs_cyc.size() > 0) begin
         check({tag, "_first_lat"}, hs_cyc[0] - en_first, 2);
         check({tag, "_contiguous"}, hs_cyc[hs_cyc.size()-1] - hs_cyc[0], beats - 1);
      end
      if (mode != 0) check({tag, "_stable_in_stall"}, stab_err, 0);
   endtask

   initial begin
      // reset
      #2 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", longint'(tvalid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_bram_en", longint'(bram_en), 0);
      check("rst_done", longint'(done), 0);
      check("rst_bram_index", longint'(bram_index), 0);
      check("rst_tdata", longint'(tdata), 0);
      check("rst_tlast", longint'(tlast), 0);
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
      check("rst_stall_cnt", longint'(stall_cnt), 0);
`endif
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(posedge clk);

      // 1: single line, start pulsed again in the DONE cycle
      run_xfer(12'h005, 12'h005, 0, 1'b0, 1'b1, "t1");
      check("t1_first_word", beat_q.size() > 0 ? longint'(beat_q[0]) : -1, 16'h0500);
      check("t1_last_word", beat_q.size() > 0 ? longint'(beat_q[beat_q.size()-1]) : -1, 16'h0523);

      // 2: four lines, no backpressure
      run_xfer(12'h000, 12'h003, 0, 1'b0, 1'b0, "t2");

      // 3: four lines, random backpressure
      run_xfer(12'h000, 12'h003, 1, 1'b0, 1'b0, "t3");

      // 4: address wrap
      run_xfer(12'hFFE, 12'h001, 0, 1'b0, 1'b0, "t4");
      check("t4_last_word", beat_q.size() > 0 ? longint'(beat_q[beat_q.size()-1]) : -1, 16'h0123);

      // 5: reset in the middle of a transfer
      begin
         bit hit40;
         hit40 = 1'b0;
         reset_log();
         pulse_start(12'h000, 12'h003);
         for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (beat_q.size() >= 40) begin
               hit40 = 1'b1;
               break;
            end
         end
         check("t5_reached_beat40", longint'(hit40), 1);
         #2 rstn = 1'b0;
         #1;
         check("t5_rst_tvalid", longint'(tvalid), 0);
         check("t5_rst_busy", longint'(busy), 0);
         check("t5_rst_bram_en", longint'(bram_en), 0);
         check("t5_rst_bram_index", longint'(bram_index), 0);
         check("t5_rst_tdata", longint'(tdata), 0);
         check("t5_rst_done", longint'(done), 0);
         repeat (2) @(posedge clk);
         @(negedge clk) rstn = 1'b1;
         reset_log();
         repeat (6) @(posedge clk);
         #1;
         check("t5_no_stray_beat", beat_q.size(), 0);
         check("t5_no_stray_done", done_cnt, 0);
         run_xfer(12'h000, 12'h000, 0, 1'b0, 1'b0, "t5");
      end

      // 6: fixed 10-cycle stall mid-stream, start pulsed while busy
      run_xfer(12'h000, 12'h003, 2, 1'b1, 1'b0, "t6");
`ifdef AXIS_BRAM_READER_STALL_CNT_EN
      check("t6_stall_cnt", longint'(stall_cnt), 10);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
